// File: rtl/ksi_pkg.sv
// Shared types for the KSI stroke replay block.
// Holds the sequencer state enum and default widths.
package ksi_pkg;

  localparam int W_DEF      = 32;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_MEAN,
    ST_REPLAY,
    ST_FLUSH
  } ksi_replay_state_t;

endpackage

// File: rtl/ksi_stroke_ram.sv
// Simple dual-port stroke buffer, one write and one registered read port.
// Ports: clk, rst_n, we/waddr/wdata, re/raddr, rdata (1-cycle latency).
module ksi_stroke_ram #(
  parameter int DW = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is cleared so outputs read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ksi_stroke_replay.sv
// Two-pass stroke capture and replay sequencer for the KSI statistics path.
// In: clk, clr, work, ink, d_valid, K1/K2, L_stroke. Out: pass strobes, replay data, busy, err.
module ksi_stroke_replay
  import ksi_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MEAN_LAT = 20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              work,
  input  logic              ink,
  input  logic              d_valid,
  input  logic [W-1:0]      FILT_K1_RE,
  input  logic [W-1:0]      FILT_K2_RE,
  input  logic [ADDR_W-1:0] L_stroke,
  output logic              acc1_new,
  output logic              acc1_en,
  output logic              ink2_new,
  output logic              fifo2_read,
  output logic              fifo2_read_f,
  output logic              acc2_front_new,
  output logic [W-1:0]      FILT_K1_RE_shift,
  output logic [W-1:0]      FILT_K2_RE_shift,
  output logic [ADDR_W-1:0] L_stroke_1,
  output logic              start_calc,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] WAIT_LAST = 8'(MEAN_LAT - 1);

  ksi_replay_state_t state, state_n;

  logic [ADDR_W-1:0] wr_cnt, rd_cnt, l_last;
  logic [7:0]        wait_cnt;
  logic              cap_start, wr_en, err_set;
  logic [2*W-1:0]    rd_data;

  assign l_last = L_stroke_1 - ADDR_W'(1);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    cap_start = 1'b0;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    if (!work) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ink) begin
            if (L_stroke != '0) begin
              cap_start = 1'b1;
              state_n   = ST_CAPTURE;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (ink) begin
            err_set = 1'b1;
            if (L_stroke != '0) cap_start = 1'b1;
            else state_n = ST_IDLE;
          end else if (d_valid) begin
            wr_en = 1'b1;
            if (wr_cnt == l_last) state_n = ST_WAIT_MEAN;
          end
        end
        ST_WAIT_MEAN: begin
          err_set = ink | d_valid;
          if (wait_cnt == WAIT_LAST) state_n = ST_REPLAY;
        end
        ST_REPLAY: begin
          err_set = ink | d_valid;
          if (rd_cnt == l_last) state_n = ST_FLUSH;
        end
        ST_FLUSH: begin
          err_set = ink;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state          <= ST_IDLE;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      wait_cnt       <= '0;
      L_stroke_1     <= '0;
      acc1_new       <= 1'b0;
      acc1_en        <= 1'b0;
      ink2_new       <= 1'b0;
      fifo2_read     <= 1'b0;
      fifo2_read_f   <= 1'b0;
      acc2_front_new <= 1'b0;
      start_calc     <= 1'b0;
      err            <= 1'b0;
    end else begin
      state <= state_n;
      if (cap_start) begin
        L_stroke_1 <= L_stroke;
        wr_cnt     <= '0;
      end else if (wr_en) begin
        wr_cnt <= (wr_cnt == l_last) ? '0 : wr_cnt + ADDR_W'(1);
      end
      if (state == ST_WAIT_MEAN && state_n == ST_WAIT_MEAN)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (state == ST_REPLAY && state_n == ST_REPLAY)
        rd_cnt <= rd_cnt + ADDR_W'(1);
      else
        rd_cnt <= '0;
      acc1_en        <= wr_en;
      acc1_new       <= wr_en && (wr_cnt == '0);
      ink2_new       <= wr_en && (state_n == ST_WAIT_MEAN);
      fifo2_read     <= (state_n == ST_REPLAY);
      // rd_cnt is still the address of the read in flight here.
      fifo2_read_f   <= fifo2_read && work;
      acc2_front_new <= fifo2_read && work && (rd_cnt == '0);
      start_calc     <= (state == ST_FLUSH) && work;
      err            <= err | err_set;
    end
  end

  ksi_stroke_ram #(
    .DW (2*W),
    .AW (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (clr),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata ({FILT_K1_RE, FILT_K2_RE}),
    .re    (fifo2_read),
    .raddr (rd_cnt),
    .rdata (rd_data)
  );

  assign FILT_K1_RE_shift = rd_data[2*W-1:W];
  assign FILT_K2_RE_shift = rd_data[W-1:0];

endmodule
